// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-outstanding memory controller.
// Data port has priority, but a waiting fetch is forced through after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic [31:0] if_data_o,
  output logic        if_done_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  input  logic [3:0]  dm_sel_i,
  output logic [31:0] dm_data_o,
  output logic        dm_done_o,
  output logic [1:0]  mc_rw_flag_o,
  output logic [31:0] mc_addr_o,
  output logic [31:0] mc_wdata_o,
  output logic [3:0]  mc_mask_o,
  input  logic        mc_busy_i,
  input  logic        mc_done_i,
  input  logic [31:0] mc_rdata_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t        state_q, state_d;
  logic          cmd_fetch_q;
  logic          cmd_we_q;
  logic [31:0]   cmd_addr_q;
  logic [31:0]   cmd_wdata_q;
  logic [3:0]    cmd_mask_q;
  logic [CW-1:0] starve_q;
  logic          discard_q;

  logic fetch_pending;
  logic any_pending;
  logic grant_fetch;
  logic flush_hit;

  assign fetch_pending = if_req_i && !if_flush_i;
  assign any_pending   = fetch_pending || dm_req_i;
  assign grant_fetch   = fetch_pending && (!dm_req_i || starve_q == LIMIT);
  assign flush_hit     = cmd_fetch_q && if_flush_i;

  assign mc_addr_o  = cmd_addr_q;
  assign mc_wdata_o = cmd_wdata_q;
  assign mc_mask_o  = cmd_mask_q;

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
    state_d      = state_q;
    mc_rw_flag_o = 2'd0;
    if_done_o    = 1'b0;
    dm_done_o    = 1'b0;
    case (state_q)
      IDLE: if (any_pending) state_d = ISSUE;
      ISSUE: begin
        mc_rw_flag_o = cmd_we_q ? 2'd2 : 2'd1;
        if (flush_hit && mc_busy_i) state_d = IDLE;
        else if (!mc_busy_i)        state_d = WAIT;
      end
      WAIT: if (mc_done_i) state_d = RESP;
      RESP: begin
        state_d = IDLE;
        // A flush landing in the strobe cycle itself still hides the completion.
        if (cmd_fetch_q) if_done_o = !discard_q && !if_flush_i;
        else             dm_done_o = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_fetch_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_mask_q  <= '0;
      starve_q    <= '0;
      discard_q   <= 1'b0;
      if_data_o   <= '0;
      dm_data_o   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (any_pending) begin
            cmd_fetch_q <= grant_fetch;
            if (grant_fetch) begin
              cmd_we_q    <= 1'b0;
              cmd_addr_q  <= if_addr_i;
              cmd_wdata_q <= '0;
              cmd_mask_q  <= 4'b1111;
              starve_q    <= '0;
            end else begin
              cmd_we_q    <= dm_we_i;
              cmd_addr_q  <= dm_addr_i;
              cmd_wdata_q <= dm_wdata_i;
              cmd_mask_q  <= dm_sel_i;
              if (!if_req_i)              starve_q <= '0;
              else if (starve_q != LIMIT) starve_q <= starve_q + CW'(1);
            end
          end
        end
        ISSUE: if (flush_hit && !mc_busy_i) discard_q <= 1'b1;
        WAIT: begin
          if (flush_hit) discard_q <= 1'b1;
          if (mc_done_i) begin
            if (cmd_fetch_q) begin
              if (!discard_q && !if_flush_i) if_data_o <= mc_rdata_i;
            end else if (!cmd_we_q) begin
              dm_data_o <= mc_rdata_i;
            end
          end
        end
        RESP: discard_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, if_flush_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_done_o;
  logic        dm_req_i, dm_we_i;
  logic [31:0] dm_addr_i, dm_wdata_i;
  logic [3:0]  dm_sel_i;
  logic [31:0] dm_data_o;
  logic        dm_done_o;
  logic [1:0]  mc_rw_flag_o;
  logic [31:0] mc_addr_o, mc_wdata_o;
  logic [3:0]  mc_mask_o;
  logic        mc_busy_i, mc_done_i;
  logic [31:0] mc_rdata_i;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_data_o(if_data_o), .if_done_o(if_done_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_sel_i(dm_sel_i),
    .dm_data_o(dm_data_o), .dm_done_o(dm_done_o),
    .mc_rw_flag_o(mc_rw_flag_o), .mc_addr_o(mc_addr_o), .mc_wdata_o(mc_wdata_o),
    .mc_mask_o(mc_mask_o), .mc_busy_i(mc_busy_i), .mc_done_i(mc_done_i),
    .mc_rdata_i(mc_rdata_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct packed {
    logic        fetch;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } txn_t;

  bit          m_active, m_accepted, m_returned, m_discard;
  int          m_starve;
  txn_t        m_txn;
  logic [31:0] m_if_data, m_dm_data;

  initial begin
    logic [1:0] e_flag;
    logic       e_if_done, e_dm_done, d, fp, take_fetch;
    m_active = 0; m_accepted = 0; m_returned = 0; m_discard = 0;
    m_starve = 0; m_txn = '0; m_if_data = '0; m_dm_data = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_flag    = (m_active && !m_accepted) ? (m_txn.we ? 2'd2 : 2'd1) : 2'd0;
      e_if_done = m_active && m_returned && m_txn.fetch && !m_discard && !if_flush_i;
      e_dm_done = m_active && m_returned && !m_txn.fetch;
      check("cmp_flag",    32'(mc_rw_flag_o), 32'(e_flag));
      check("cmp_addr",    mc_addr_o, m_txn.addr);
      check("cmp_wdata",   mc_wdata_o, m_txn.wdata);
      check("cmp_mask",    32'(mc_mask_o), 32'(m_txn.mask));
      check("cmp_if_done", 32'(if_done_o), 32'(e_if_done));
      check("cmp_dm_done", 32'(dm_done_o), 32'(e_dm_done));
      check("cmp_if_data", if_data_o, m_if_data);
      check("cmp_dm_data", dm_data_o, m_dm_data);
      check("cmp_done_excl", 32'(if_done_o & dm_done_o), 32'd0);
      // advance the model using the inputs that the next rising edge will see
      if (rst) begin
        m_active = 0; m_accepted = 0; m_returned = 0; m_discard = 0;
        m_starve = 0; m_txn = '0; m_if_data = '0; m_dm_data = '0;
      end else if (!m_active) begin
        fp = if_req_i && !if_flush_i;
        if (fp || dm_req_i) begin
          take_fetch = fp && (!dm_req_i || m_starve == LIMIT);
          if (take_fetch) begin
            m_txn    = '{fetch: 1'b1, we: 1'b0, addr: if_addr_i, wdata: 32'd0, mask: 4'hF};
            m_starve = 0;
          end else begin
            m_txn    = '{fetch: 1'b0, we: dm_we_i, addr: dm_addr_i, wdata: dm_wdata_i, mask: dm_sel_i};
            m_starve = if_req_i ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
          end
          m_active = 1; m_accepted = 0; m_returned = 0; m_discard = 0;
        end
      end else if (!m_accepted) begin
        if (m_txn.fetch && if_flush_i && mc_busy_i) m_active = 0;
        else if (!mc_busy_i) begin
          m_accepted = 1;
          if (m_txn.fetch && if_flush_i) m_discard = 1;
        end
      end else if (!m_returned) begin
        d = m_discard || (m_txn.fetch && if_flush_i);
        m_discard = d;
        if (mc_done_i) begin
          m_returned = 1;
          if (m_txn.fetch) begin
            if (!d) m_if_data = mc_rdata_i;
          end else if (!m_txn.we) m_dm_data = mc_rdata_i;
        end
      end else begin
        m_active = 0; m_discard = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_flag(output int cycles, output bit ok);
    ok = 0;
    cycles = 0;
    for (int i = 0; i < 50; i++) begin
      if (mc_rw_flag_o != 2'd0) begin
        ok = 1;
        break;
      end
      tick();
      cycles++;
    end
    check("flag_seen_in_budget", 32'(ok), 32'd1);
  endtask

  // Serve one command: busy for busy_cyc cycles, mc_done after lat cycles in WAIT.
  task automatic serve(input int busy_cyc, input int lat, input logic [31:0] rdata,
                       input logic [1:0] exp_f, input logic [31:0] exp_a, input logic [3:0] exp_m);
    int cyc;
    bit ok;
    wait_flag(cyc, ok);
    if (!ok) return;
    check("grant_flag", 32'(mc_rw_flag_o), 32'(exp_f));
    check("grant_addr", mc_addr_o, exp_a);
    check("grant_mask", 32'(mc_mask_o), 32'(exp_m));
    mc_busy_i = (busy_cyc > 0);
    for (int k = 1; k <= busy_cyc; k++) begin
      tick();
      check("busy_hold_flag", 32'(mc_rw_flag_o), 32'(exp_f));
      check("busy_hold_addr", mc_addr_o, exp_a);
      mc_busy_i = (k < busy_cyc);
    end
    tick();
    check("flag_after_accept", 32'(mc_rw_flag_o), 32'd0);
    for (int k = 1; k < lat; k++) tick();
    mc_done_i  = 1'b1;
    mc_rdata_i = rdata;
    tick();
    mc_done_i  = 1'b0;
  endtask

  logic [31:0] exp_addr [10] = '{32'h500, 32'h500, 32'h500, 32'h500, 32'h400,
                                 32'h500, 32'h500, 32'h500, 32'h500, 32'h400};

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  ok;
    rst = 1'b1;
    if_req_i = 0; if_flush_i = 0; if_addr_i = '0;
    dm_req_i = 0; dm_we_i = 0; dm_addr_i = '0; dm_wdata_i = '0; dm_sel_i = '0;
    mc_busy_i = 0; mc_done_i = 0; mc_rdata_i = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_flag",    32'(mc_rw_flag_o), 32'd0);
    check("reset_if_data", if_data_o, 32'd0);
    check("reset_done",    32'({if_done_o, dm_done_o}), 32'd0);

    // single fetch, done three cycles after the flag
    if_addr_i = 32'h100;
    if_req_i  = 1'b1;
    wait_flag(cyc, ok);
    check("fetch_latency", 32'(cyc), 32'd1);
    check("fetch_wdata",   mc_wdata_o, 32'd0);
    serve(0, 3, 32'hDEADBEEF, 2'd1, 32'h100, 4'hF);
    check("fetch_done",    32'(if_done_o), 32'd1);
    check("fetch_data",    if_data_o, 32'hDEADBEEF);
    tick();
    if_req_i = 1'b0;
    check("fetch_done_one_cycle", 32'(if_done_o), 32'd0);

    // simultaneous fetch and data write: write first
    if_addr_i = 32'h300; if_req_i = 1'b1;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h200;
    dm_wdata_i = 32'h12345678; dm_sel_i = 4'b0011;
    serve(0, 2, 32'hFFFF0000, 2'd2, 32'h200, 4'b0011);
    check("write_done",    32'(dm_done_o), 32'd1);
    check("write_no_data", dm_data_o, 32'd0);
    tick();
    dm_req_i = 1'b0; dm_we_i = 1'b0;
    serve(0, 1, 32'hCAFEF00D, 2'd1, 32'h300, 4'hF);
    check("fetch2_data", if_data_o, 32'hCAFEF00D);
    tick();
    if_req_i = 1'b0;

    // starvation limit with both requests held
    if_addr_i = 32'h400; if_req_i = 1'b1;
    dm_addr_i = 32'h500; dm_we_i = 1'b0; dm_sel_i = 4'hF; dm_req_i = 1'b1;
    for (int i = 0; i < 10; i++) serve(0, 1, 32'hA000_0000 + 32'(i), 2'd1, exp_addr[i], 4'hF);
    check("starve_last_fetch_data", if_data_o, 32'hA000_0009);
    check("starve_last_dm_data",    dm_data_o, 32'hA000_0008);
    tick();
    if_req_i = 1'b0; dm_req_i = 1'b0;

    // controller busy for five cycles
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h800;
    dm_wdata_i = 32'h55AA55AA; dm_sel_i = 4'b1100;
    serve(5, 2, 32'h0, 2'd2, 32'h800, 4'b1100);
    check("busy_write_done", 32'(dm_done_o), 32'd1);
    tick();
    dm_req_i = 1'b0; dm_we_i = 1'b0;

    // flush of a fetch stuck in ISSUE
    if_addr_i = 32'h900; if_req_i = 1'b1;
    wait_flag(cyc, ok);
    mc_busy_i = 1'b1; if_flush_i = 1'b1; if_req_i = 1'b0;
    tick();
    check("cancel_flag", 32'(mc_rw_flag_o), 32'd0);
    if_flush_i = 1'b0; mc_busy_i = 1'b0;
    repeat (3) tick();
    check("cancel_no_issue", 32'(mc_rw_flag_o), 32'd0);

    // flush while the fetch waits for memory
    if_addr_i = 32'hA00; if_req_i = 1'b1;
    wait_flag(cyc, ok);
    tick();
    if_flush_i = 1'b1; if_req_i = 1'b0;
    tick();
    if_flush_i = 1'b0;
    mc_done_i = 1'b1; mc_rdata_i = 32'hBADBAD00;
    tick();
    mc_done_i = 1'b0;
    check("flush_no_done", 32'(if_done_o), 32'd0);
    check("flush_data_kept", if_data_o, 32'hA000_0009);
    tick();
    check("flush_no_done_late", 32'(if_done_o), 32'd0);
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'hB00; dm_sel_i = 4'hF;
    serve(0, 2, 32'h0C0FFEE0, 2'd1, 32'hB00, 4'hF);
    check("post_flush_dm_done", 32'(dm_done_o), 32'd1);
    check("post_flush_dm_data", dm_data_o, 32'h0C0FFEE0);
    tick();
    dm_req_i = 1'b0;

    // reset while waiting, then a stale mc_done
    dm_req_i = 1'b1; dm_addr_i = 32'hC00;
    wait_flag(cyc, ok);
    tick();
    tick();
    rst = 1'b1; dm_req_i = 1'b0;
    tick();
    rst = 1'b0;
    mc_done_i = 1'b1; mc_rdata_i = 32'h1111_2222;
    tick();
    mc_done_i = 1'b0;
    check("rst_flag",    32'(mc_rw_flag_o), 32'd0);
    check("rst_addr",    mc_addr_o, 32'd0);
    check("rst_dm_data", dm_data_o, 32'd0);
    check("rst_if_data", if_data_o, 32'd0);
    check("rst_done",    32'({if_done_o, dm_done_o}), 32'd0);
    tick();
    check("late_done_ignored", 32'({if_done_o, dm_done_o}), 32'd0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
